// File: rtl/qam_mapper_axis.sv
`default_nettype none
// ============================================================================
// Module   : qam_mapper_axis
// Purpose  : Transmit-side Gray-coded QAM mapper (QPSK / 16-QAM / 64-QAM).
//            Packs an AXI-Stream byte stream (MSB first) into BPS-bit symbols
//            and emits signed I/Q samples on an AXI-Stream output.  Frame
//            boundaries are propagated; a trailing partial symbol is
//            zero-padded.
// Ports    : clock, reset (async, active-high)
//            in_tdata[7:0], in_tvalid, in_tready, in_tlast   - byte input
//            out_tdata[2*DW-1:0] = {I, Q}, out_tvalid, out_tready,
//            out_tlast                                       - symbol output
//            busy - buffered bits, pending output or pending flush
// Revision : 1.0 - initial release
// ============================================================================
module qam_mapper_axis #(
    parameter int BPS   = 4,    // 2, 4 or 6
    parameter int DW    = 16,
    parameter int SCALE = 4096
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [7:0]      in_tdata,
    input  logic            in_tvalid,
    output logic            in_tready,
    input  logic            in_tlast,
    output logic [2*DW-1:0] out_tdata,
    output logic            out_tvalid,
    input  logic            out_tready,
    output logic            out_tlast,
    output logic            busy
);

    localparam int         c_half = BPS / 2;
    localparam int         c_max  = (1 << c_half) - 1;
    localparam logic [3:0] c_bps  = 4'(BPS);

    // Bit buffer is MSB-aligned; every bit below the valid count is zero,
    // which is what gives the flush symbol its zero padding for free.
    logic [15:0]     bitbuf_q, bitbuf_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            flush_q, flush_d;
    logic [2*DW-1:0] out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;

    logic            w_ready;
    logic            w_accept;
    logic            w_sym_avail;
    logic            w_load;
    logic            w_last;
    logic [BPS-1:0]  w_sym;
    logic [3:0]      w_cnt_rem;
    logic [15:0]     w_buf_rem;

    // Gray index -> signed amplitude (2*b - max) * SCALE
    function automatic logic [DW-1:0] map_half(input logic [c_half-1:0] g);
        logic [c_half-1:0] b;
        logic signed [31:0] lvl;
        logic signed [31:0] prod;
        b[c_half-1] = g[c_half-1];
        for (int k = c_half - 2; k >= 0; k--) begin
            b[k] = b[k+1] ^ g[k];
        end
        lvl  = $signed({{(31-c_half){1'b0}}, b, 1'b0}) - c_max;
        prod = lvl * SCALE;
        return prod[DW-1:0];
    endfunction

    always_comb begin
        w_ready     = !reset && !flush_q && (cnt_q < c_bps);
        w_accept    = in_tvalid && w_ready;
        w_sym_avail = (cnt_q >= c_bps) || (flush_q && (cnt_q != 4'd0));
        w_load      = w_sym_avail && (!out_valid_q || out_tready);
        w_sym       = bitbuf_q[15 -: BPS];

        // Buffer state after removing the extracted symbol (if any)
        if (!w_load) begin
            w_cnt_rem = cnt_q;
        end else if (cnt_q >= c_bps) begin
            w_cnt_rem = cnt_q - c_bps;
        end else begin
            w_cnt_rem = 4'd0;
        end
        w_buf_rem = w_load ? (bitbuf_q << BPS) : bitbuf_q;

        bitbuf_d = w_buf_rem;
        cnt_d    = w_cnt_rem;
        if (w_accept) begin
            // New byte lands directly below the bits that remain
            bitbuf_d = w_buf_rem | ({in_tdata, 8'h00} >> w_cnt_rem);
            cnt_d    = w_cnt_rem + 4'd8;
        end

        w_last = flush_q && (w_cnt_rem == 4'd0) && !w_accept;

        flush_d = flush_q;
        if (w_load && w_last) begin
            flush_d = 1'b0;
        end
        if (w_accept && in_tlast) begin
            flush_d = 1'b1;
        end

        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        if (w_load) begin
            out_data_d  = {map_half(w_sym[BPS-1 -: c_half]), map_half(w_sym[c_half-1:0])};
            out_valid_d = 1'b1;
            out_last_d  = w_last;
        end else if (out_tready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bitbuf_q    <= '0;
            cnt_q       <= '0;
            flush_q     <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            bitbuf_q    <= bitbuf_d;
            cnt_q       <= cnt_d;
            flush_q     <= flush_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign in_tready  = w_ready;
    assign out_tdata  = out_data_q;
    assign out_tvalid = out_valid_q;
    assign out_tlast  = out_last_q;
    assign busy       = (cnt_q != 4'd0) || out_valid_q || flush_q;

endmodule
`default_nettype wire

// File: tb/tb_qam_mapper_axis.sv
`default_nettype none
// ============================================================================
// Module   : tb_qam_mapper_axis
// Purpose  : Directed bench for qam_mapper_axis with one instance per
//            constellation (BPS = 2, 4, 6) sharing clock and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qam_mapper_axis;

    logic             clock = 1'b0;
    logic             reset;
    logic [2:0][7:0]  in_tdata;
    logic [2:0]       in_tvalid;
    logic [2:0]       in_tready;
    logic [2:0]       in_tlast;
    logic [2:0][31:0] out_tdata;
    logic [2:0]       out_tvalid;
    logic [2:0]       out_tready;
    logic [2:0]       out_tlast;
    logic [2:0]       busy;

    int errors = 0;
    int checks = 0;

    logic [32:0] got0[$];
    logic [32:0] got1[$];
    logic [32:0] got2[$];
    logic [32:0] exp_q[$];
    int          m_acc;
    int          m_n;

    always #5 clock = ~clock;

    qam_mapper_axis #(.BPS(2), .DW(16), .SCALE(4096)) dut_qpsk (
        .clock(clock), .reset(reset),
        .in_tdata(in_tdata[0]), .in_tvalid(in_tvalid[0]), .in_tready(in_tready[0]), .in_tlast(in_tlast[0]),
        .out_tdata(out_tdata[0]), .out_tvalid(out_tvalid[0]), .out_tready(out_tready[0]), .out_tlast(out_tlast[0]),
        .busy(busy[0]));

    qam_mapper_axis #(.BPS(4), .DW(16), .SCALE(4096)) dut_qam16 (
        .clock(clock), .reset(reset),
        .in_tdata(in_tdata[1]), .in_tvalid(in_tvalid[1]), .in_tready(in_tready[1]), .in_tlast(in_tlast[1]),
        .out_tdata(out_tdata[1]), .out_tvalid(out_tvalid[1]), .out_tready(out_tready[1]), .out_tlast(out_tlast[1]),
        .busy(busy[1]));

    qam_mapper_axis #(.BPS(6), .DW(16), .SCALE(4096)) dut_qam64 (
        .clock(clock), .reset(reset),
        .in_tdata(in_tdata[2]), .in_tvalid(in_tvalid[2]), .in_tready(in_tready[2]), .in_tlast(in_tlast[2]),
        .out_tdata(out_tdata[2]), .out_tvalid(out_tvalid[2]), .out_tready(out_tready[2]), .out_tlast(out_tlast[2]),
        .busy(busy[2]));

    // Output handshakes are captured mid-cycle, ahead of the edge that completes them
    always @(negedge clock) begin
        if (out_tvalid[0] && out_tready[0]) got0.push_back({out_tlast[0], out_tdata[0]});
        if (out_tvalid[1] && out_tready[1]) got1.push_back({out_tlast[1], out_tdata[1]});
        if (out_tvalid[2] && out_tready[2]) got2.push_back({out_tlast[2], out_tdata[2]});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int got_size(input logic [1:0] idx);
        case (idx)
            2'd0:    return got0.size();
            2'd1:    return got1.size();
            default: return got2.size();
        endcase
    endfunction

    function automatic logic [32:0] got_at(input logic [1:0] idx, input int k);
        case (idx)
            2'd0:    return got0[k];
            2'd1:    return got1[k];
            default: return got2[k];
        endcase
    endfunction

    task automatic clear_got(input logic [1:0] idx);
        case (idx)
            2'd0:    got0.delete();
            2'd1:    got1.delete();
            default: got2.delete();
        endcase
    endtask

    function automatic logic [32:0] pk(input int i, input int q, input logic l);
        logic [31:0] iv;
        logic [31:0] qv;
        iv = i;
        qv = q;
        return {l, iv[15:0], qv[15:0]};
    endfunction

    // Reference Gray tables, written out per constellation
    function automatic int lvl(input int bps, input int g);
        if (bps == 2) return (g != 0) ? 1 : -1;
        if (bps == 4) begin
            case (g)
                0: return -3;
                1: return -1;
                3: return 1;
                default: return 3;
            endcase
        end
        case (g)
            0: return -7;
            1: return -5;
            3: return -3;
            2: return -1;
            6: return 1;
            7: return 3;
            5: return 5;
            default: return 7;
        endcase
    endfunction

    task automatic m_emit(input int bps, input int sym, input logic l);
        int half;
        half = bps / 2;
        exp_q.push_back(pk(lvl(bps, sym >> half) * 4096, lvl(bps, sym & ((1 << half) - 1)) * 4096, l));
    endtask

    task automatic m_byte(input int bps, input logic [7:0] b, input logic l);
        for (int i = 7; i >= 0; i--) begin
            m_acc = (m_acc << 1) | int'(b[i]);
            m_n++;
            if (m_n == bps) begin
                m_emit(bps, m_acc, l && (i == 0));
                m_acc = 0;
                m_n   = 0;
            end
        end
        if (l && m_n > 0) begin
            m_emit(bps, m_acc << (bps - m_n), 1'b1);
            m_acc = 0;
            m_n   = 0;
        end
    endtask

    task automatic send_byte(input logic [1:0] idx, input logic [7:0] d, input logic l);
        int   n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        in_tdata[idx]  = d;
        in_tlast[idx]  = l;
        in_tvalid[idx] = 1'b1;
        while (!acc && n < 100) begin
            @(negedge clock);
            acc = in_tready[idx];
            @(posedge clock);
            #1;
            n++;
        end
        in_tvalid[idx] = 1'b0;
        in_tlast[idx]  = 1'b0;
        chk($sformatf("accept_i%0d_%02h", idx, d), 64'(acc), 64'd1);
    endtask

    task automatic wait_syms(input logic [1:0] idx, input int n);
        int k;
        k = 0;
        while (got_size(idx) < n && k < 200) begin
            tick();
            k++;
        end
        chk($sformatf("wait_syms_i%0d", idx), 64'(got_size(idx) >= n), 64'd1);
    endtask

    task automatic compare_all(input logic [1:0] idx, input string tag);
        int n;
        chk({tag, "_count"}, 64'(got_size(idx)), 64'(exp_q.size()));
        n = (got_size(idx) < exp_q.size()) ? got_size(idx) : exp_q.size();
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s_sym%0d", tag, k), 64'(got_at(idx, k)), 64'(exp_q[k]));
        end
    endtask

    initial begin
        logic [7:0]  bp_bytes[4];
        logic [7:0]  rb[200];
        logic [31:0] prev_d;
        logic        prev_l;
        logic        have_prev;
        logic        saw_low;
        logic        acc;
        int          bi;
        int          nl;

        reset      = 1'b1;
        in_tdata   = '0;
        in_tvalid  = '0;
        in_tlast   = '0;
        out_tready = 3'b111;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_in_tready", 64'(in_tready), 64'd0);
        chk("rst_out_tvalid", 64'(out_tvalid), 64'd0);
        chk("rst_out_tlast", 64'(out_tlast), 64'd0);
        chk("rst_out_tdata", 64'(|out_tdata), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        tick();
        chk("idle_in_tready", 64'(in_tready), 64'd7);

        // ---------------- QPSK, 0xB4 single-byte frame ----------------
        send_byte(2'd0, 8'hB4, 1'b1);
        chk("t1_ready_low_flush", 64'(in_tready[0]), 64'd0);
        chk("t1_valid_at_n", 64'(out_tvalid[0]), 64'd0);
        tick();
        chk("t1_valid_at_n1", 64'(out_tvalid[0]), 64'd1);
        wait_syms(2'd0, 4);
        repeat (4) tick();
        exp_q.delete();
        exp_q.push_back(pk(4096, -4096, 1'b0));
        exp_q.push_back(pk(4096, 4096, 1'b0));
        exp_q.push_back(pk(-4096, 4096, 1'b0));
        exp_q.push_back(pk(-4096, -4096, 1'b1));
        compare_all(2'd0, "t1");
        chk("t1_busy_idle", 64'(busy[0]), 64'd0);
        chk("t1_ready_back", 64'(in_tready[0]), 64'd1);

        // ---------------- 16-QAM, 0x1E then 0x00+tlast ----------------
        send_byte(2'd1, 8'h1E, 1'b0);
        send_byte(2'd1, 8'h00, 1'b1);
        wait_syms(2'd1, 4);
        repeat (4) tick();
        exp_q.delete();
        exp_q.push_back(pk(-12288, -4096, 1'b0));
        exp_q.push_back(pk(4096, 12288, 1'b0));
        exp_q.push_back(pk(-12288, -12288, 1'b0));
        exp_q.push_back(pk(-12288, -12288, 1'b1));
        compare_all(2'd1, "t2");

        // ---------------- 64-QAM, 0xFF then 0x00+tlast, padded ----------------
        send_byte(2'd2, 8'hFF, 1'b0);
        send_byte(2'd2, 8'h00, 1'b1);
        wait_syms(2'd2, 3);
        repeat (6) tick();
        exp_q.delete();
        exp_q.push_back(pk(12288, 12288, 1'b0));
        exp_q.push_back(pk(4096, -28672, 1'b0));
        exp_q.push_back(pk(-28672, -28672, 1'b1));
        compare_all(2'd2, "t3");

        // ---------------- 16-QAM backpressure ----------------
        clear_got(2'd1);
        exp_q.delete();
        m_acc = 0;
        m_n   = 0;
        bp_bytes = '{8'h3C, 8'hA5, 8'h69, 8'hF0};
        for (int k = 0; k < 4; k++) m_byte(4, bp_bytes[k], k == 3);
        bi        = 0;
        have_prev = 1'b0;
        saw_low   = 1'b0;
        prev_d    = '0;
        prev_l    = 1'b0;
        for (int cyc = 0; cyc < 200 && (bi < 4 || got1.size() < 8); cyc++) begin
            out_tready[1] = (cyc >= 12);
            if (bi < 4) begin
                in_tdata[1]  = bp_bytes[bi];
                in_tlast[1]  = (bi == 3);
                in_tvalid[1] = 1'b1;
            end else begin
                in_tvalid[1] = 1'b0;
                in_tlast[1]  = 1'b0;
            end
            @(negedge clock);
            if (out_tvalid[1] && !out_tready[1]) begin
                if (have_prev) begin
                    chk("t4_hold_data", 64'(out_tdata[1]), 64'(prev_d));
                    chk("t4_hold_last", 64'(out_tlast[1]), 64'(prev_l));
                end
                prev_d    = out_tdata[1];
                prev_l    = out_tlast[1];
                have_prev = 1'b1;
                if (!in_tready[1]) saw_low = 1'b1;
            end else begin
                have_prev = 1'b0;
            end
            acc = in_tvalid[1] && in_tready[1];
            @(posedge clock);
            #1;
            if (acc) bi++;
        end
        in_tvalid[1]  = 1'b0;
        in_tlast[1]   = 1'b0;
        out_tready[1] = 1'b1;
        chk("t4_ready_fell", 64'(saw_low), 64'd1);
        chk("t4_all_accepted", 64'(bi), 64'd4);
        repeat (4) tick();
        compare_all(2'd1, "t4");

        // ---------------- 64-QAM random handshakes, 200 bytes ----------------
        clear_got(2'd2);
        exp_q.delete();
        m_acc = 0;
        m_n   = 0;
        for (int k = 0; k < 200; k++) begin
            rb[k] = 8'($urandom_range(0, 255));
            m_byte(6, rb[k], (k % 7 == 6) || (k == 199));
        end
        bi           = 0;
        in_tvalid[2] = 1'b0;
        for (int cyc = 0; cyc < 5000 && (bi < 200 || got2.size() < exp_q.size()); cyc++) begin
            out_tready[2] = ($urandom_range(0, 3) != 0);
            if (!in_tvalid[2] && bi < 200 && $urandom_range(0, 2) != 0) begin
                in_tdata[2]  = rb[bi];
                in_tlast[2]  = (bi % 7 == 6) || (bi == 199);
                in_tvalid[2] = 1'b1;
            end
            @(negedge clock);
            acc = in_tvalid[2] && in_tready[2];
            @(posedge clock);
            #1;
            if (acc) begin
                bi++;
                in_tvalid[2] = 1'b0;
                in_tlast[2]  = 1'b0;
            end
        end
        out_tready[2] = 1'b1;
        repeat (4) tick();
        chk("t5_bytes_accepted", 64'(bi), 64'd200);
        chk("t5_sym_total", 64'(got2.size()), 64'd286);
        nl = 0;
        foreach (got2[k]) if (got2[k][32]) nl++;
        chk("t5_tlast_count", 64'(nl), 64'd29);
        compare_all(2'd2, "t5");

        // ---------------- asynchronous reset mid-frame ----------------
        clear_got(2'd1);
        out_tready[1] = 1'b0;
        send_byte(2'd1, 8'hAB, 1'b0);
        tick();
        tick();
        chk("t6_valid_before_rst", 64'(out_tvalid[1]), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_valid", 64'(out_tvalid), 64'd0);
        chk("t6_rst_last", 64'(out_tlast), 64'd0);
        chk("t6_rst_ready", 64'(in_tready), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        @(posedge clock);
        #1;
        reset         = 1'b0;
        out_tready[1] = 1'b1;
        tick();
        send_byte(2'd1, 8'h1E, 1'b1);
        wait_syms(2'd1, 2);
        repeat (4) tick();
        exp_q.delete();
        exp_q.push_back(pk(-12288, -4096, 1'b0));
        exp_q.push_back(pk(4096, 12288, 1'b1));
        compare_all(2'd1, "t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
